// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost-full/empty thresholds and sticky error flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads; undefined gives a registered 1-cycle read.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_accept;
    logic             w_wr_accept;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    // Handshake: a read is taken only when the FIFO holds data (no bypass from a
    // same-cycle write); a write is taken when not full, or when full but a read
    // frees a slot on the same edge. Refused requests only raise the sticky flags.
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_rd_accept = rd_en && !w_empty;
    assign w_wr_accept = wr_en && (!w_full || w_rd_accept);

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_accept) r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && !w_wr_accept) r_overflow  <= 1'b1;
            if (rd_en && !w_rd_accept) r_underflow <= 1'b1;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !rst) r_mem[r_wr_ptr] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = !w_empty;
`else
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_CNT);
    assign almost_empty = (r_count <= AE_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=5, AF_LEVEL=3, AE_LEVEL=2), either read mode.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int exp_cnt);
        check({tag, ".count"}, 32'(count), 32'(exp_cnt));
        check({tag, ".full"}, 32'(full), 32'(exp_cnt == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(exp_cnt >= 3));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(exp_cnt <= 2));
    endtask

    // driver: one accepted write
    task automatic push(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        exp_q.push_back(d);
    endtask

    // driver + scoreboard: one pop, checked against the expected queue
    task automatic pop(input string tag);
        logic [WIDTH-1:0] exp_d;
        exp_d = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, ".rd_valid"}, 32'(rd_valid), 1);
        check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_d));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, ".rd_valid"}, 32'(rd_valid), 1);
        check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_d));
`endif
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset / idle state
        check_flags("reset", 0);
        check("reset.rd_valid", 32'(rd_valid), 0);
        check("reset.overflow", 32'(overflow), 0);
        check("reset.underflow", 32'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("reset.rd_data", 32'(rd_data), 0);
`endif

        // fill to full, thresholds tracked at every level
        for (int i = 1; i <= DEPTH; i++) begin
            push(WIDTH'(i));
            check_flags($sformatf("fill%0d", i), i);
        end

        // write while full and no read: rejected
        wr_en   = 1'b1;
        wr_data = 8'h06;
        tick();
        wr_en   = 1'b0;
        check_flags("ovf", DEPTH);
        check("ovf.overflow", 32'(overflow), 1);
        check("ovf.underflow", 32'(underflow), 0);

        // drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            pop($sformatf("drain%0d", i));
            check_flags($sformatf("drain%0d", i), DEPTH - i);
        end
        tick();
        check("idle.rd_valid", 32'(rd_valid), 0);

        // read while empty: rejected
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_flags("udf", 0);
        check("udf.underflow", 32'(underflow), 1);
        check("udf.rd_valid", 32'(rd_valid), 0);

        // asynchronous reset in the middle of a burst
        push(8'h71);
        push(8'h72);
        push(8'h73);
        wr_en   = 1'b1;
        wr_data = 8'h74;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        check("burst.rd_valid", 32'(rd_valid), 1);
        check("burst.rd_data", 32'(rd_data), 32'h71);
`endif
        check_flags("burst", 3);
        #2 rst = 1'b1;
        #1;
        check_flags("async_rst", 0);
        check("async_rst.rd_valid", 32'(rd_valid), 0);
        check("async_rst.overflow", 32'(overflow), 0);
        check("async_rst.underflow", 32'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("async_rst.rd_data", 32'(rd_data), 0);
`endif
        #2 rst = 1'b0;
        exp_q.delete();
        tick();

        // full: simultaneous write and read, then drain across the pointer wrap
        for (int i = 0; i < DEPTH; i++) push(WIDTH'(8'h11 + i));
        check_flags("refill", DEPTH);
`ifdef SYNC_FIFO_FWFT_EN
        check("full_rw.head", 32'(rd_data), 32'h11);
`endif
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'hAA);
`ifndef SYNC_FIFO_FWFT_EN
        check("full_rw.rd_valid", 32'(rd_valid), 1);
        check("full_rw.rd_data", 32'(rd_data), 32'h11);
`endif
        check_flags("full_rw", DEPTH);
        check("full_rw.overflow", 32'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) pop($sformatf("wrap%0d", i));
        check_flags("wrap_end", 0);

        // empty: simultaneous write and read, read refused, no bypass
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.push_back(8'h5A);
        check_flags("empty_rw", 1);
        check("empty_rw.underflow", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
        check("empty_rw.rd_valid", 32'(rd_valid), 0);
`endif
        pop("empty_rw_pop");
        check_flags("empty_rw_pop", 0);

`ifdef SYNC_FIFO_FWFT_EN
        // word falls through without rd_en, then is acknowledged
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        check("fwft.rd_valid", 32'(rd_valid), 1);
        check("fwft.rd_data", 32'(rd_data), 32'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fwft.empty", 32'(empty), 1);
        check("fwft.rd_valid_after", 32'(rd_valid), 0);
`else
        tick();
        check("hold.rd_valid", 32'(rd_valid), 0);
        check("hold.rd_data", 32'(rd_data), 32'h5A);
`endif

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
